// File: rtl/fetch_redirect.sv
// Instruction-fetch stage: owns the PC, issues synchronous inst-RAM reads,
// hands {pc, inst, adel} to ID over the over/allow_in handshake, and takes
// redirects from WB (exception / cancel) and branch targets from ID.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC       = 32'hbfc00000,
    parameter logic [31:0] EXC_ENTER_ADDR = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_en,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        ID_allow_in,
    input  logic [32:0] jbr_bus,
    input  logic [32:0] exc_bus,
    input  logic        cancel,
    output logic        IF_over,
    output logic [64:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic        adel_reg;
    logic        br_pend_reg;
    logic [31:0] br_tgt_reg;

    logic        jbr_taken;
    logic [31:0] jbr_target;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        redirect;
    logic        aligned;
    logic        transfer;
    logic [31:0] pc_next;

    // The exception entry point always arrives on exc_bus; the parameter is
    // kept only as a reference value and is folded into an unused net.
    logic unused_exc_enter_addr;
    assign unused_exc_enter_addr = ^EXC_ENTER_ADDR;

    assign jbr_taken  = jbr_bus[32];
    assign jbr_target = jbr_bus[31:0];
    assign exc_valid  = exc_bus[32];
    assign exc_pc     = exc_bus[31:0];
    assign redirect   = exc_valid | cancel;
    assign aligned    = (pc_reg[1:0] == 2'b00);

    // A redirect suppresses the handshake so nothing reaches ID that cycle.
    assign IF_over  = (state_reg == S_READY) & ~redirect & ~reset;
    assign transfer = IF_over & ID_allow_in;

    // RAM read is requested only from FETCH with an aligned PC.
    assign inst_en   = (state_reg == S_FETCH) & aligned & ~reset;
    assign inst_addr = pc_reg;

    assign IF_ID_bus = {pc_reg, inst_reg, adel_reg};
    assign IF_pc     = pc_reg;
    assign IF_inst   = inst_reg;

    // Next PC at a transfer: same-cycle branch, then pending branch, then pc+4.
    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (jbr_taken) begin
            pc_next = jbr_target;
        end else if (br_pend_reg) begin
            pc_next = br_tgt_reg;
        end
    end

    // Fetch FSM, PC register and pending-branch tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            pc_reg      <= RESET_PC;
            inst_reg    <= 32'd0;
            adel_reg    <= 1'b0;
            br_pend_reg <= 1'b0;
            br_tgt_reg  <= 32'd0;
        end else if (redirect) begin
            // Returning RAM data next cycle is ignored because we are not in WAIT.
            state_reg   <= S_FETCH;
            br_pend_reg <= 1'b0;
            if (exc_valid) begin
                pc_reg <= exc_pc;
            end
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (aligned) begin
                        state_reg <= S_WAIT;
                    end else begin
                        // Misaligned fetch: present a NOP flagged with AdEL.
                        inst_reg  <= 32'd0;
                        adel_reg  <= 1'b1;
                        state_reg <= S_READY;
                    end
                end
                S_WAIT: begin
                    inst_reg  <= inst_rdata;
                    adel_reg  <= 1'b0;
                    state_reg <= S_READY;
                end
                S_READY: begin
                    if (ID_allow_in) begin
                        pc_reg    <= pc_next;
                        state_reg <= S_FETCH;
                    end
                end
                default: begin
                    state_reg <= S_FETCH;
                end
            endcase

            // A transfer consumes any pending target (or the same-cycle one);
            // a branch seen outside a transfer is held for the delay slot.
            if (transfer) begin
                br_pend_reg <= 1'b0;
            end else if (jbr_taken) begin
                br_pend_reg <= 1'b1;
                br_tgt_reg  <= jbr_target;
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: a per-cycle vector table for the main
// pipeline traffic plus short hand-written reset sequences.
module tb_fetch_redirect;

    logic        clk;
    logic        reset;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        ID_allow_in;
    logic [32:0] jbr_bus;
    logic [32:0] exc_bus;
    logic        cancel;
    logic        IF_over;
    logic [64:0] IF_ID_bus;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;

    int tests_run;
    int tests_failed;

    fetch_redirect dut (
        .clk        (clk),
        .reset      (reset),
        .inst_en    (inst_en),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .ID_allow_in(ID_allow_in),
        .jbr_bus    (jbr_bus),
        .exc_bus    (exc_bus),
        .cancel     (cancel),
        .IF_over    (IF_over),
        .IF_ID_bus  (IF_ID_bus),
        .IF_pc      (IF_pc),
        .IF_inst    (IF_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction RAM model: word at 0xbfc00000 is fixed, others are addr+0x10000000.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'hbfc00000) return 32'h24020001;
        return a + 32'h10000000;
    endfunction

    always @(posedge clk) begin
        if (inst_en) inst_rdata <= ram_word(inst_addr);
    end

    typedef struct {
        logic        allow;
        logic        jbr;
        logic [31:0] jtgt;
        logic        exc;
        logic [31:0] epc;
        logic        cncl;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_over;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_adel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic al, input logic jb, input logic [31:0] jt,
                               input logic ex, input logic [31:0] ep, input logic cn,
                               input logic en, input logic ov,
                               input logic [31:0] pc, input logic [31:0] ins, input logic ad);
        vec_t r;
        r.allow = al; r.jbr = jb; r.jtgt = jt; r.exc = ex; r.epc = ep; r.cncl = cn;
        r.exp_en = en; r.exp_addr = pc; r.exp_over = ov;
        r.exp_pc = pc; r.exp_inst = ins; r.exp_adel = ad;
        return r;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic en, input logic [31:0] addr,
                                 input logic ov, input logic [31:0] pc,
                                 input logic [31:0] ins, input logic ad);
        chk({tag, " inst_en"},   65'(inst_en),   65'(en));
        chk({tag, " inst_addr"}, 65'(inst_addr), 65'(addr));
        chk({tag, " IF_over"},   65'(IF_over),   65'(ov));
        chk({tag, " IF_ID_bus"}, IF_ID_bus,      {pc, ins, ad});
        chk({tag, " IF_pc"},     65'(IF_pc),     65'(pc));
        chk({tag, " IF_inst"},   65'(IF_inst),   65'(ins));
    endtask

    task automatic idle_inputs();
        ID_allow_in = 1'b0;
        jbr_bus     = 33'd0;
        exc_bus     = 33'd0;
        cancel      = 1'b0;
    endtask

    localparam logic [31:0] Z = 32'd0;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        inst_rdata   = 32'hdeadbeef;
        reset        = 1'b1;
        idle_inputs();

        // Table: one entry per cycle after reset release.
        //           allow jbr jtgt          exc epc           cncl en over pc            inst          adel
        tbl.push_back(v(0, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00000, 32'h00000000, 0)); // 0 FETCH
        tbl.push_back(v(0, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00000, 32'h00000000, 0)); // 1 WAIT
        for (int i = 0; i < 5; i++)                                                                     // 2-6 hold
            tbl.push_back(v(0, 0, Z,        0, Z,            0, 0, 1, 32'hbfc00000, 32'h24020001, 0));
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 1, 32'hbfc00000, 32'h24020001, 0)); // 7 transfer
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00004, 32'h24020001, 0)); // 8 FETCH
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00004, 32'h24020001, 0)); // 9 WAIT
        tbl.push_back(v(0, 1, 32'hbfc00100, 0, Z,            0, 0, 1, 32'hbfc00004, 32'hcfc00004, 0)); // 10 pend
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 1, 32'hbfc00004, 32'hcfc00004, 0)); // 11 transfer
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00100, 32'hcfc00004, 0)); // 12
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00100, 32'hcfc00004, 0)); // 13
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 1, 32'hbfc00100, 32'hcfc00100, 0)); // 14
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00104, 32'hcfc00100, 0)); // 15
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00104, 32'hcfc00100, 0)); // 16
        tbl.push_back(v(1, 1, 32'hbfc00100, 0, Z,            0, 0, 1, 32'hbfc00104, 32'hcfc00104, 0)); // 17 coincident
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00100, 32'hcfc00104, 0)); // 18
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00100, 32'hcfc00104, 0)); // 19
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 1, 32'hbfc00100, 32'hcfc00100, 0)); // 20
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00104, 32'hcfc00100, 0)); // 21
        tbl.push_back(v(1, 0, Z,            1, 32'hbfc00380, 0, 0, 0, 32'hbfc00104, 32'hcfc00100, 0)); // 22 exc in WAIT
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00380, 32'hcfc00100, 0)); // 23
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00380, 32'hcfc00100, 0)); // 24
        tbl.push_back(v(0, 1, 32'hbfc00102, 0, Z,            0, 0, 1, 32'hbfc00380, 32'hcfc00380, 0)); // 25 pend misaligned
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 1, 32'hbfc00380, 32'hcfc00380, 0)); // 26 transfer
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00102, 32'hcfc00380, 0)); // 27 FETCH, no read
        tbl.push_back(v(0, 0, Z,            0, Z,            0, 0, 1, 32'hbfc00102, 32'h00000000, 1)); // 28 AdEL
        tbl.push_back(v(1, 0, Z,            0, Z,            1, 0, 0, 32'hbfc00102, 32'h00000000, 1)); // 29 cancel
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00102, 32'h00000000, 1)); // 30 refetch misaligned
        tbl.push_back(v(1, 0, Z,            1, 32'hbfc00380, 0, 0, 0, 32'hbfc00102, 32'h00000000, 1)); // 31 exc in READY
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00380, 32'h00000000, 1)); // 32
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00380, 32'h00000000, 1)); // 33
        tbl.push_back(v(1, 0, Z,            0, Z,            1, 0, 0, 32'hbfc00380, 32'hcfc00380, 0)); // 34 cancel aligned
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00380, 32'hcfc00380, 0)); // 35 refetch same pc
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00380, 32'hcfc00380, 0)); // 36
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 1, 32'hbfc00380, 32'hcfc00380, 0)); // 37
        tbl.push_back(v(1, 1, 32'hbfc00500, 1, 32'hbfc00400, 0, 1, 0, 32'hbfc00384, 32'hcfc00380, 0)); // 38 jbr+exc
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hbfc00400, 32'hcfc00380, 0)); // 39
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hbfc00400, 32'hcfc00380, 0)); // 40
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 1, 32'hbfc00400, 32'hcfc00400, 0)); // 41 dropped branch
        tbl.push_back(v(1, 0, Z,            1, 32'hfffffffc, 0, 1, 0, 32'hbfc00404, 32'hcfc00400, 0)); // 42
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 1, 0, 32'hfffffffc, 32'hcfc00400, 0)); // 43
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 0, 32'hfffffffc, 32'hcfc00400, 0)); // 44
        tbl.push_back(v(1, 0, Z,            0, Z,            0, 0, 1, 32'hfffffffc, 32'h0ffffffc, 0)); // 45 wrap
        tbl.push_back(v(0, 0, Z,            0, Z,            0, 1, 0, 32'h00000000, 32'h0ffffffc, 0)); // 46 FETCH 0

        // Reset state.
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_outputs("reset", 1'b0, 32'hbfc00000, 1'b0, 32'hbfc00000, 32'd0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            ID_allow_in = tbl[i].allow;
            jbr_bus     = {tbl[i].jbr, tbl[i].jtgt};
            exc_bus     = {tbl[i].exc, tbl[i].epc};
            cancel      = tbl[i].cncl;
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), tbl[i].exp_en, tbl[i].exp_addr, tbl[i].exp_over,
                          tbl[i].exp_pc, tbl[i].exp_inst, tbl[i].exp_adel);
            $display("[TB] vec%0d pc=%h over=%b en=%b bus=%h", i, IF_pc, IF_over, inst_en, IF_ID_bus);
            @(posedge clk); #1;
        end

        // DUT is now in WAIT for pc 0: assert reset mid-operation.
        idle_inputs();
        ID_allow_in = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_outputs("rst_in_wait", 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h0ffffffc, 1'b0);
        $display("[TB] reset in WAIT pc=%h en=%b", IF_pc, inst_en);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_outputs("after_rst", 1'b1, 32'hbfc00000, 1'b0, 32'hbfc00000, 32'd0, 1'b0);
        $display("[TB] after reset pc=%h en=%b over=%b", IF_pc, inst_en, IF_over);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_outputs("after_rst_ready", 1'b0, 32'hbfc00000, 1'b1, 32'hbfc00000, 32'h24020001, 1'b0);
        $display("[TB] first instruction after reset bus=%h", IF_ID_bus);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC, issues synchronous inst-RAM reads and presents {pc, inst} to ID through the valid/over/allow_in handshake.
- Consumes the redirect traffic driven back from WB (exc_bus, cancel) and from ID (jbr_bus), so it is the receiving end of the exception-PC interface.
- Flags fetch address errors (AdEL) forward so WB can raise exception code 4.

Parameters:
RESET_PC, 32'hbfc00000, PC loaded by reset
EXC_ENTER_ADDR, 32'hbfc00380, documentation only; the target always comes from exc_bus[31:0]

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
inst_en  out  1  inst-RAM read enable
inst_addr  out  32  inst-RAM byte address
inst_rdata  in  32  inst-RAM data, valid the cycle after inst_en
ID_allow_in  in  1  ID can accept an instruction this cycle
jbr_bus  in  33  {jbr_taken, jbr_target}, one-cycle pulse from ID
exc_bus  in  33  {exc_valid, exc_pc} from WB
cancel  in  1  flush from WB; kills the in-flight fetch
IF_over  out  1  IF_ID_bus holds a valid instruction
IF_ID_bus  out  65  {pc[31:0], inst[31:0], adel}
IF_pc  out  32  current PC register, for display
IF_inst  out  32  latched instruction, for display

Behaviour:
- Reset values:
  - pc=RESET_PC, state=FETCH, inst_r=0, adel_r=0, br_pend=0, br_tgt=0.
  - Outputs: IF_over=0, IF_ID_bus={RESET_PC,32'b0,1'b0}.
  - inst_en=0 while reset is high.
  - A reset asserted mid-operation discards all state the same way.
- States:
  - FETCH: if pc[1:0]==0, drive inst_en=1 and inst_addr=pc, go to WAIT. If misaligned, drive inst_en=0, set inst_r=0 and adel_r=1, go straight to READY.
  - WAIT: capture inst_r<=inst_rdata and adel_r<=0, go to READY.
  - READY: IF_over=1. When ID_allow_in=1 (transfer), set pc<=next_pc and go to FETCH; otherwise hold with the bus stable.
- inst_en is asserted only in FETCH and is combinational from state and pc. inst_addr=pc at all times.
- Latency and throughput: 2 cycles from FETCH to IF_over for an aligned PC, 1 cycle for a misaligned PC. One instruction per 3 cycles at best.
- next_pc priority at a transfer:
  1. jbr_taken the same cycle → jbr_target.
  2. br_pend → br_tgt.
  3. Otherwise pc+4, modulo 2^32 (0xfffffffc wraps to 0).
- Pending branch: a jbr_taken pulse outside a transfer cycle sets br_pend=1 and br_tgt=jbr_target; a later pulse overwrites both. br_pend clears on the transfer that consumes it. This covers the delay slot, which is the instruction transferred after the branch sits in ID.
- Redirect: when exc_valid=1 or cancel=1, in any state:
  - pc<=exc_pc if exc_valid, else unchanged (cancel alone refetches the current pc).
  - state<=FETCH, br_pend<=0.
  - IF_over is forced to 0 in that cycle, so no transfer occurs even if ID_allow_in=1.
  - Any RAM data returning in the next cycle is ignored, because state is FETCH and not WAIT.
  - Redirect has priority over jbr_bus and over the transfer.
- Simultaneous jbr_taken and redirect: the redirect wins and the branch is dropped.
- IF_ID_bus={pc, inst_r, adel_r}. IF_pc=pc. IF_inst=inst_r.
- adel=1 implies inst=0; ID decodes it as a NOP and WB takes the exception.

Test Plan:
- Release reset with ID_allow_in=1 and RAM returning 0x24020001 for 0xbfc00000 → inst_en=1 with inst_addr=0xbfc00000 the first cycle after release; IF_over=1 two cycles later with bus {0xbfc00000, 0x24020001, 0}; next fetch address is 0xbfc00004.
- Hold ID_allow_in=0 for 5 cycles in READY → IF_over stays 1, bus unchanged, inst_en=0; PC advances only after allow_in rises.
- Pulse jbr_bus={1,0xbfc00100} while READY and not transferring → next transfer fetches 0xbfc00100 and the following one 0xbfc00104. Repeat with the pulse coincident with the transfer → same result, no stale br_pend.
- exc_bus={1,0xbfc00380} during WAIT with ID_allow_in=1 → IF_over=0 that cycle; stale rdata dropped; FETCH issues 0xbfc00380 on the next cycle.
- jbr_bus with target 0xbfc00102 → READY one cycle after FETCH with inst_en never asserted, bus {0xbfc00102, 0, 1}.
- cancel=1 with exc_valid=0, simultaneous with ID_allow_in=1 in READY → no transfer, pc unchanged, refetch of the same address. Separately, reset asserted in WAIT → next cycle state=FETCH, pc=0xbfc00000, IF_over=0.
